// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 clock/data lines, shifts
// in 11-bit frames (start, 8 data LSB first, odd parity, stop), and turns the
// accepted bytes into make codes with F0 (break) and E0 (extended) prefixes.
//
// Ports:
//   clk        system clock, all state changes on rising edge
//   rst        asynchronous active-high reset
//   ps2_clk    raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data   raw PS/2 data from the keyboard (asynchronous)
//   keycode    current make scancode, 8'h00 = no key
//   key_valid  one-cycle pulse when a make code is written to keycode
//   key_ext    current keycode was preceded by E0
//   frame_err  one-cycle pulse on parity, stop-bit or timeout error
module ps2_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          data_s1_q, data_s2_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          brk_q, brk_d;
  logic          extp_q, extp_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          key_valid_q, key_valid_d;
  logic          key_ext_q, key_ext_d;
  logic          frame_err_q, frame_err_d;

  logic fall_edge;
  logic timeout;
  logic frame_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b0;
      clk_s2_q    <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_s1_q   <= 1'b0;
      data_s2_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      brk_q       <= 1'b0;
      extp_q      <= 1'b0;
      keycode_q   <= '0;
      key_valid_q <= 1'b0;
      key_ext_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      data_s1_q   <= ps2_data;
      data_s2_q   <= data_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      brk_q       <= brk_d;
      extp_q      <= extp_d;
      keycode_q   <= keycode_d;
      key_valid_q <= key_valid_d;
      key_ext_q   <= key_ext_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_s2_q;
  // An edge in the same cycle as expiry wins, so timeout is masked by it.
  assign timeout   = (state_q != IDLE) && !fall_edge &&
                     (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  // Nine bits (data + parity) must hold an odd number of ones, stop must be 1.
  assign frame_ok  = (^{shift_q, parity_q}) & data_s2_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    brk_d       = brk_q;
    extp_d      = extp_q;
    keycode_d   = keycode_q;
    key_ext_d   = key_ext_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == IDLE || fall_edge) ? '0 : to_cnt_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fall_edge && !data_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_edge) begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_edge) begin
          parity_d = data_s2_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_edge) begin
          state_d = IDLE;
          if (!frame_ok) begin
            frame_err_d = 1'b1;
            brk_d       = 1'b0;
            extp_d      = 1'b0;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            extp_d = 1'b1;
          end else if (brk_q) begin
            if (shift_q == keycode_q) begin
              keycode_d = 8'h00;
              key_ext_d = 1'b0;
            end
            brk_d  = 1'b0;
            extp_d = 1'b0;
          end else begin
            keycode_d   = shift_q;
            key_ext_d   = extp_q;
            key_valid_d = 1'b1;
            extp_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      extp_d      = 1'b0;
    end
  end

  assign keycode   = keycode_q;
  assign key_valid = key_valid_q;
  assign key_ext   = key_ext_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

  localparam int TO   = 200;
  localparam int HALF = 10;
  localparam int GAP  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       key_ext;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_valid(key_valid), .key_ext(key_ext),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Cumulative pulse monitor; tests work on deltas between snapshots.
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         overlap   = 0;
  logic [7:0] kc_at_valid = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        valid_cnt   = valid_cnt + 1;
        kc_at_valid = keycode;
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (key_valid && frame_err) overlap = overlap + 1;
    end
  end

  // Reference keyboard model: tracks what the host should see per frame.
  logic [7:0] m_kc   = 8'h00;
  logic       m_ext  = 1'b0;
  logic       m_brk  = 1'b0;
  logic       m_extp = 1'b0;

  task automatic model_reset();
    m_kc = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good,
                             output int ev, output int ee);
    ev = 0; ee = 0;
    if (!good) begin
      ee = 1; m_brk = 0; m_extp = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_extp = 1;
    else if (m_brk) begin
      if (b == m_kc) begin m_kc = 8'h00; m_ext = 0; end
      m_brk = 0; m_extp = 0;
    end else begin
      m_kc = b; m_ext = m_extp; m_extp = 0; ev = 1;
    end
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  int v0, e0, o0;
  task automatic snap();
    @(negedge clk);
    v0 = valid_cnt; e0 = err_cnt; o0 = overlap;
  endtask

  task automatic check_outputs(input int idx, input int kc, input int ext,
                               input int ev, input int ee);
    @(negedge clk);
    chk("keycode", idx, keycode, kc);
    chk("key_ext", idx, key_ext, ext);
    chk("valid_pulses", idx, valid_cnt - v0, ev);
    chk("err_pulses", idx, err_cnt - e0, ee);
    chk("valid_err_overlap", idx, overlap - o0, 0);
    if (ev == 1) chk("keycode_at_valid", idx, kc_at_valid, kc);
  endtask

  // Model-checked frame: expected values come from the reference model.
  task automatic model_run(input int idx, input logic [7:0] b, input bit bp, input bit bs);
    int ev, ee;
    snap();
    send_frame(b, bp, bs);
    model_frame(b, !(bp || bs), ev, ee);
    check_outputs(idx, m_kc, m_ext, ev, ee);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] kc;
    bit         ext;
    int         ev;
    int         ee;
  } vec_t;

  vec_t vec[17];

  initial begin
    int ev, ee;
    logic [7:0] b;
    bit bad;

    vec[0]  = '{8'h16, 0, 0, 8'h16, 0, 1, 0};
    vec[1]  = '{8'hF0, 0, 0, 8'h16, 0, 0, 0};
    vec[2]  = '{8'h16, 0, 0, 8'h00, 0, 0, 0};
    vec[3]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
    vec[4]  = '{8'h5A, 0, 0, 8'h5A, 1, 1, 0};
    vec[5]  = '{8'h1C, 1, 0, 8'h5A, 1, 0, 1};
    vec[6]  = '{8'h5A, 0, 0, 8'h5A, 0, 1, 0};
    vec[7]  = '{8'h5A, 0, 0, 8'h5A, 0, 1, 0};
    vec[8]  = '{8'hF0, 0, 0, 8'h5A, 0, 0, 0};
    vec[9]  = '{8'h33, 0, 0, 8'h5A, 0, 0, 0};
    vec[10] = '{8'hE0, 0, 0, 8'h5A, 0, 0, 0};
    vec[11] = '{8'hF0, 0, 0, 8'h5A, 0, 0, 0};
    vec[12] = '{8'h5A, 0, 1, 8'h5A, 0, 0, 1};
    vec[13] = '{8'h5A, 0, 0, 8'h5A, 0, 1, 0};
    vec[14] = '{8'hE0, 0, 0, 8'h5A, 0, 0, 0};
    vec[15] = '{8'h1C, 1, 0, 8'h5A, 0, 0, 1};
    vec[16] = '{8'h1C, 0, 0, 8'h1C, 0, 1, 0};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_keycode", 0, keycode, 0);
    chk("rst_key_valid", 0, key_valid, 0);
    chk("rst_key_ext", 0, key_ext, 0);
    chk("rst_frame_err", 0, frame_err, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      snap();
      send_frame(vec[i].b, vec[i].bad_par, vec[i].bad_stop);
      model_frame(vec[i].b, !(vec[i].bad_par || vec[i].bad_stop), ev, ee);
      check_outputs(i, vec[i].kc, vec[i].ext, vec[i].ev, vec[i].ee);
    end

    // Timeout mid-frame after E0; the error must also drop the E0 prefix.
    model_run(100, 8'hE0, 0, 0);
    snap();
    send_partial(5);
    repeat (2 * TO) @(posedge clk);
    model_frame(8'h00, 0, ev, ee);
    check_outputs(101, m_kc, m_ext, 0, 1);
    snap();
    send_frame(8'h45, 0, 0);
    model_frame(8'h45, 1, ev, ee);
    check_outputs(102, 8'h45, 0, 1, 0);

    // F0 then reset: outputs cleared during reset, break forgotten.
    model_run(103, 8'hF0, 0, 0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("inrst_keycode", 104, keycode, 0);
    chk("inrst_key_valid", 104, key_valid, 0);
    chk("inrst_key_ext", 104, key_ext, 0);
    chk("inrst_frame_err", 104, frame_err, 0);
    rst = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    snap();
    send_frame(8'h16, 0, 0);
    check_outputs(105, 8'h16, 0, 1, 0);
    model_frame(8'h16, 1, ev, ee);

    // Reset mid-frame: no error, next frame received normally.
    snap();
    send_partial(3);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (2 * TO) @(posedge clk);
    check_outputs(106, 0, 0, 0, 0);
    model_run(107, 8'h1C, 0, 0);

    // Randomized frames against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hF0;
        2:       b = 8'hE0;
        3, 4:    b = m_kc;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      model_run(200 + i, b, bad && $urandom_range(0, 1) == 0, bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the number of idle clk cycles inside a frame before the frame is abandoned (1 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 SHALL have port keycode  output  8  current make scancode, registered; feeds the downstream scancode decoder; 8'h00 = no key.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse, asserted in the cycle a make code is written to keycode.
REQ-008 SHALL have port key_ext  output  1  high when the current keycode was preceded by the E0 prefix; updated together with keycode.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-011 SHALL detect a falling edge as synced ps2_clk 1 in the previous cycle and 0 in the current cycle, and sample synced ps2_data only on that edge.
REQ-012 SHALL receive 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-014 IDLE: edge with data 0 -> DATA with bit counter 0; edge with data 1 is ignored and the FSM stays in IDLE.
REQ-015 DATA: each edge shifts in one bit; after the 8th bit -> PARITY.
REQ-016 PARITY: the edge captures the parity bit -> STOP.
REQ-017 STOP: the edge ends the frame -> IDLE; the byte is accepted only if the 9 bits (data plus parity) contain an odd number of ones and the stop bit is 1; otherwise frame_err pulses and the byte is discarded.
REQ-018 SHALL clear the timeout counter on every edge and when in IDLE; in DATA, PARITY or STOP, reaching TIMEOUT_CYCLES -> IDLE with a frame_err pulse.
REQ-019 If an edge and the timeout occur in the same cycle, the edge SHALL win: no error, and the counter clears.
REQ-020 Accepted byte 8'hF0 SHALL set break_pending and produce no output.
REQ-021 Accepted byte 8'hE0 SHALL set ext_pending and produce no output.
REQ-022 Any other accepted byte with break_pending set is a release: if it equals keycode, keycode -> 8'h00 and key_ext -> 0; otherwise no output change; no key_valid; both pending flags clear.
REQ-023 Any other accepted byte without break_pending is a make: keycode <= byte, key_ext <= ext_pending, key_valid pulses, ext_pending clears.
REQ-024 A typematic repeat of the same make code SHALL pulse key_valid again; keycode keeps its value.
REQ-025 Latency: key_valid and the new keycode SHALL appear in the cycle after the cycle in which the stop-bit edge is detected.
REQ-026 Any frame_err SHALL clear break_pending and ext_pending.
REQ-027 key_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst is high: FSM IDLE; bit counter, shift register, timeout counter, both pending flags and the synchronizers cleared to 0; keycode 8'h00; key_valid, key_ext and frame_err 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no frame_err; reception resumes at the next start bit after release.

Verification
REQ-030 Frame 0x16 (data 0,1,1,0,1,0,0,0, parity 0, stop 1) -> keycode 0x16, a single key_valid pulse, key_ext 0.
REQ-031 Frames F0, 16 while keycode is 0x16 -> keycode 0x00, no key_valid, no frame_err.
REQ-032 Frames E0, 5A -> keycode 0x5A, key_ext 1, one key_valid pulse after the 5A frame only.
REQ-033 Frame 0x1C with the parity bit inverted -> frame_err pulse, keycode unchanged, no key_valid.
REQ-034 Start bit plus 5 data bits, then ps2_clk held high for more than TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; a following frame 0x45 -> keycode 0x45 with key_valid.
REQ-035 Frame F0, then rst pulsed, then frame 0x16 -> all outputs 0 during reset; 0x16 is treated as a make: keycode 0x16 with key_valid.
